// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: 5-stage MIPS hazard unit with EX forwarding, load-use stall and branch flush FSM.
// Ports: clk/rst_n (async active-low); rs_d/rt_d ID sources; rs_e/rt_e/dst_e/mem_to_reg_e EX info;
// rd_m/rd_w/reg_write_m/reg_write_w writeback info; branch_m/zero_m branch resolve; ext_stall freeze;
// fwd_a_e/fwd_b_e operand selects; stall_f/stall_d/flush_d/flush_e pipeline controls.
// Define HAZARD_PERF_CNT_EN to add stall_cnt/flush_cnt saturating performance counters.
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int LOAD_LAT = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] dst_e,
  input  logic              mem_to_reg_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              branch_m,
  input  logic              zero_m,
  input  logic              ext_stall,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);
  localparam int MX = LOAD_LAT > FLUSH_CYCLES ? LOAD_LAT : FLUSH_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD_WAIT = 2'd1, FLUSH = 2'd2;
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic bt, lu, sf, fd, fe;
  logic [1:0] fa, fb;
  assign bt = branch_m && zero_m;
  assign lu = mem_to_reg_e && dst_e != '0 && (dst_e == rs_d || dst_e == rt_d);
  assign fa = (reg_write_m && rd_m != '0 && rd_m == rs_e) ? 2'b01 :
              (reg_write_w && rd_w != '0 && rd_w == rs_e) ? 2'b10 : 2'b00;
  assign fb = (reg_write_m && rd_m != '0 && rd_m == rt_e) ? 2'b01 :
              (reg_write_w && rd_w != '0 && rd_w == rt_e) ? 2'b10 : 2'b00;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    sf = 1'b0;
    fd = 1'b0;
    fe = 1'b0;
    if (bt) begin
      fd = 1'b1;
      fe = 1'b1;
      state_nx = FLUSH_CYCLES > 1 ? FLUSH : IDLE;
      cnt_nx = CW'(FLUSH_CYCLES - 1);
    end else if (ext_stall) begin
      sf = 1'b1;
    end else if (state == FLUSH) begin
      fd = 1'b1;
      fe = 1'b1;
      state_nx = cnt == CW'(1) ? IDLE : FLUSH;
      cnt_nx = cnt - CW'(1);
    end else if (state == LOAD_WAIT) begin
      sf = 1'b1;
      fe = 1'b1;
      state_nx = cnt == CW'(1) ? IDLE : LOAD_WAIT;
      cnt_nx = cnt - CW'(1);
    end else if (lu) begin
      sf = 1'b1;
      fe = 1'b1;
      state_nx = LOAD_LAT > 1 ? LOAD_WAIT : IDLE;
      cnt_nx = CW'(LOAD_LAT - 1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // Outputs are forced low while reset is held so the clear is visible without a clock edge.
  assign fwd_a_e = rst_n ? fa : 2'b00;
  assign fwd_b_e = rst_n ? fb : 2'b00;
  assign stall_f = rst_n & sf;
  assign stall_d = rst_n & sf;
  assign flush_d = rst_n & fd;
  assign flush_e = rst_n & fe;
`ifdef HAZARD_PERF_CNT_EN
  // A load-use stall is the only case where stall and bubble are raised together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (sf && fe && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (bt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule
